// File: rtl/switch_in_buf.sv
// switch_in_buf: switch ingress buffer.
// Byte-serial frames enter on data_in/sw_enable_in and pass through a hold register (HR)
// into a show-ahead FIFO. Each entry carries {data, sof, eof, err}. read_out gives
// almost-full backpressure; a full FIFO mid-frame sends the frame to an overflow state
// that truncates it and marks its terminator with err.
// Optional build macro SW_IN_ADDR_FILTER_EN: drop whole frames whose destination byte
// addresses a port >= NUM_PORTS.
module switch_in_buf #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned NUM_PORTS = 4,
  parameter int unsigned AFULL     = DEPTH - 2,
  localparam int unsigned PW       = $clog2(NUM_PORTS),
  localparam int unsigned LW       = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data_in,
  input  logic              sw_enable_in,
  output logic              read_out,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sof,
  output logic              out_eof,
  output logic              out_err,
  output logic [PW-1:0]     out_port,
  output logic [LW-1:0]     level,
  output logic [15:0]       drop_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [LW-1:0] LvlOne   = LW'(1);
  localparam logic [LW-1:0] AfullLvl = LW'(AFULL);
  localparam logic [AW:0]   PtrOne   = (AW + 1)'(1);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              sof;
    logic              eof;
    logic              err;
  } entry_t;

  typedef enum logic [1:0] {StIdle, StRx, StOvf, StFlush} state_e;

  entry_t            mem [DEPTH];
  logic [AW:0]       wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]     level_q, level_d;
  state_e            state_q, state_d;
  logic [DATA_W-1:0] hr_q, hr_d;
  logic              hr_sof_q, hr_sof_d;
  logic              err_q, err_d;
  logic              drop_q, drop_d;
  logic              cnt_inc;
  logic [15:0]       drop_cnt_q;
  logic              read_out_q;
  logic [PW-1:0]     port_q;
  logic              push, pop, full, empty, can_push, addr_bad;
  entry_t            push_entry, head;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign pop      = !empty && out_ready;
  // A same-cycle pop frees the slot, so a push into a full FIFO is legal then.
  assign can_push = !full || pop;
  assign head     = mem[rd_ptr_q[AW-1:0]];

`ifdef SW_IN_ADDR_FILTER_EN
  assign addr_bad = |(data_in >> PW);
`else
  assign addr_bad = 1'b0;
`endif

  // Ingress FSM: HR management, FIFO write requests, drop tracking.
  always_comb begin
    state_d    = state_q;
    hr_d       = hr_q;
    hr_sof_d   = hr_sof_q;
    err_d      = err_q;
    drop_d     = drop_q;
    cnt_inc    = 1'b0;
    push       = 1'b0;
    push_entry = '{data: hr_q, sof: hr_sof_q, eof: 1'b0, err: 1'b0};

    // A dropped frame is counted when its envelope falls.
    if (drop_q && !sw_enable_in) begin
      drop_d  = 1'b0;
      cnt_inc = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (sw_enable_in && !drop_q) begin
          if (addr_bad) begin
            drop_d = 1'b1;
          end else begin
            hr_d     = data_in;
            hr_sof_d = 1'b1;
            err_d    = 1'b0;
            state_d  = StRx;
          end
        end
      end
      StRx: begin
        if (sw_enable_in) begin
          if (can_push) begin
            push     = 1'b1;
            hr_d     = data_in;
            hr_sof_d = 1'b0;
          end else begin
            state_d = StOvf;
          end
        end else if (can_push) begin
          push           = 1'b1;
          push_entry.eof = 1'b1;
          state_d        = StIdle;
        end else begin
          state_d = StFlush;
        end
      end
      StOvf: begin
        if (!sw_enable_in) begin
          err_d   = 1'b1;
          state_d = StFlush;
        end
      end
      StFlush: begin
        // A new frame cannot start while the terminator is still pending.
        if (sw_enable_in && !drop_q) drop_d = 1'b1;
        if (can_push) begin
          push           = 1'b1;
          push_entry.eof = 1'b1;
          push_entry.err = err_q;
          state_d        = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Occupancy next-state.
  always_comb begin
    level_d = level_q;
    if (push && !pop) begin
      level_d = level_q + LvlOne;
    end else if (!push && pop) begin
      level_d = level_q - LvlOne;
    end
  end

  // FIFO storage; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q[AW-1:0]] <= push_entry;
  end

  // State, pointers, counters and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      hr_q       <= '0;
      hr_sof_q   <= 1'b0;
      err_q      <= 1'b0;
      drop_q     <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      read_out_q <= 1'b0;
      drop_cnt_q <= '0;
      port_q     <= '0;
    end else begin
      state_q    <= state_d;
      hr_q       <= hr_d;
      hr_sof_q   <= hr_sof_d;
      err_q      <= err_d;
      drop_q     <= drop_d;
      level_q    <= level_d;
      read_out_q <= (level_d >= AfullLvl) || (state_d == StOvf) || (state_d == StFlush);
      if (push) wr_ptr_q <= wr_ptr_q + PtrOne;
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrOne;
        if (head.sof) port_q <= head.data[PW-1:0];
      end
      if (cnt_inc && (drop_cnt_q != 16'hFFFF)) drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign read_out  = read_out_q;
  assign level     = level_q;
  assign drop_cnt  = drop_cnt_q;
  assign out_valid = !empty;
  assign out_data  = empty ? '0 : head.data;
  assign out_sof   = !empty && head.sof;
  assign out_eof   = !empty && head.eof;
  assign out_err   = !empty && head.err;
  // Bypass the port while a start-of-frame sits at the head, else hold the last one.
  assign out_port  = (!empty && head.sof) ? head.data[PW-1:0] : port_q;

endmodule

// File: tb/tb_switch_in_buf.sv
// Directed testbench for switch_in_buf (default parameters).
module tb_switch_in_buf;

  logic       clk;
  logic       rst_n;
  logic [7:0] data_in;
  logic       sw_enable_in;
  logic       read_out;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_sof;
  logic       out_eof;
  logic       out_err;
  logic [1:0] out_port;
  logic [4:0] level;
  logic [15:0] drop_cnt;

  int vectors;
  int miscompares;

  switch_in_buf dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .data_in      (data_in),
    .sw_enable_in (sw_enable_in),
    .read_out     (read_out),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_sof      (out_sof),
    .out_eof      (out_eof),
    .out_err      (out_err),
    .out_port     (out_port),
    .level        (level),
    .drop_cnt     (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vectors      = 0;
    miscompares  = 0;
    rst_n        = 1'b0;
    data_in      = 8'h00;
    sw_enable_in = 1'b0;
    out_ready    = 1'b0;

    // Reset values
    #2;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_read_out", 32'(read_out), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_flags", 32'({out_sof, out_eof, out_err}), 32'd0);
    chk("rst_port", 32'(out_port), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_drop", 32'(drop_cnt), 32'd0);
    #15 rst_n = 1'b1;
    tick();

    // Single 3-byte frame, consumer always ready
    out_ready    = 1'b1;
    sw_enable_in = 1'b1;
    data_in      = 8'h02;
    tick();
    chk("t1_not_yet", 32'(out_valid), 32'd0);
    data_in = 8'hAA;
    tick();
    chk("t1_b0_valid", 32'(out_valid), 32'd1);
    chk("t1_b0_data", 32'(out_data), 32'h02);
    chk("t1_b0_flags", 32'({out_sof, out_eof, out_err}), 32'b100);
    chk("t1_b0_port", 32'(out_port), 32'd2);
    data_in = 8'h55;
    tick();
    chk("t1_b1_data", 32'(out_data), 32'hAA);
    chk("t1_b1_flags", 32'({out_sof, out_eof, out_err}), 32'b000);
    chk("t1_b1_port", 32'(out_port), 32'd2);
    chk("t1_level", 32'(level), 32'd1);
    sw_enable_in = 1'b0;
    tick();
    chk("t1_b2_data", 32'(out_data), 32'h55);
    chk("t1_b2_flags", 32'({out_sof, out_eof, out_err}), 32'b010);
    tick();
    chk("t1_empty", 32'(out_valid), 32'd0);
    chk("t1_level0", 32'(level), 32'd0);

    // One-byte frame
    sw_enable_in = 1'b1;
    data_in      = 8'h01;
    tick();
    sw_enable_in = 1'b0;
    tick();
    chk("t2_data", 32'(out_data), 32'h01);
    chk("t2_flags", 32'({out_valid, out_sof, out_eof, out_err}), 32'b1110);
    chk("t2_port", 32'(out_port), 32'd1);
    tick();
    chk("t2_empty", 32'(out_valid), 32'd0);
    chk("t2_port_held", 32'(out_port), 32'd1);

    // Backpressure and overflow: 20-byte frame, consumer stalled
    out_ready    = 1'b0;
    sw_enable_in = 1'b1;
    for (int i = 0; i < 20; i++) begin
      data_in = (i == 0) ? 8'h03 : 8'(32'h40 + i);
      tick();
      if (i == 13) begin
        chk("t3_lvl13", 32'(level), 32'd13);
        chk("t3_ro13", 32'(read_out), 32'd0);
      end
      if (i == 14) begin
        chk("t3_lvl14", 32'(level), 32'd14);
        chk("t3_ro14", 32'(read_out), 32'd1);
      end
      if (i == 17) begin
        chk("t3_lvl_ovf", 32'(level), 32'd16);
        chk("t3_ro_ovf", 32'(read_out), 32'd1);
      end
    end
    sw_enable_in = 1'b0;
    tick();
    chk("t3_head_data", 32'(out_data), 32'h03);
    chk("t3_head_sof", 32'(out_sof), 32'd1);
    chk("t3_head_port", 32'(out_port), 32'd3);
    chk("t3_ro_flush", 32'(read_out), 32'd1);
    out_ready = 1'b1;
    tick();
    chk("t3_lvl_swap", 32'(level), 32'd16);
    chk("t3_port_loaded", 32'(out_port), 32'd3);
    for (int j = 0; j < 14; j++) tick();
    chk("t3_e16_data", 32'(out_data), 32'h4F);
    chk("t3_e16_eof", 32'(out_eof), 32'd0);
    tick();
    chk("t3_term_data", 32'(out_data), 32'h50);
    chk("t3_term_flags", 32'({out_valid, out_sof, out_eof, out_err}), 32'b1011);
    tick();
    chk("t3_empty", 32'(out_valid), 32'd0);
    chk("t3_ro_clear", 32'(read_out), 32'd0);
    chk("t3_drop0", 32'(drop_cnt), 32'd0);

    // New frame while terminator pending is dropped whole
    out_ready    = 1'b0;
    sw_enable_in = 1'b1;
    for (int i = 0; i < 17; i++) begin
      data_in = (i == 0) ? 8'h02 : 8'(32'h60 + i);
      tick();
    end
    sw_enable_in = 1'b0;
    tick();
    chk("t4_ro_flush", 32'(read_out), 32'd1);
    sw_enable_in = 1'b1;
    data_in      = 8'h01;
    tick();
    data_in = 8'h99;
    tick();
    tick();
    sw_enable_in = 1'b0;
    tick();
    chk("t4_drop1", 32'(drop_cnt), 32'd1);
    out_ready = 1'b1;
    tick();
    for (int j = 0; j < 15; j++) begin
      chk("t4_no_dropped_byte", 32'(out_data == 8'h99), 32'd0);
      tick();
    end
    chk("t4_term_data", 32'(out_data), 32'h70);
    chk("t4_term_flags", 32'({out_valid, out_sof, out_eof, out_err}), 32'b1010);
    chk("t4_lvl1", 32'(level), 32'd1);
    tick();
    chk("t4_empty", 32'(out_valid), 32'd0);

    // Asynchronous reset in the middle of a frame
    out_ready    = 1'b0;
    sw_enable_in = 1'b1;
    data_in      = 8'h02;
    tick();
    data_in = 8'h33;
    tick();
    chk("t5_pre_valid", 32'(out_valid), 32'd1);
    data_in = 8'h44;
    #2;
    rst_n        = 1'b0;
    sw_enable_in = 1'b0;
    #1;
    chk("t5_valid", 32'(out_valid), 32'd0);
    chk("t5_data", 32'(out_data), 32'd0);
    chk("t5_level", 32'(level), 32'd0);
    chk("t5_port", 32'(out_port), 32'd0);
    chk("t5_drop", 32'(drop_cnt), 32'd0);
    chk("t5_ro", 32'(read_out), 32'd0);
    #2 rst_n = 1'b1;
    tick();
    tick();
    chk("t5_no_partial", 32'(out_valid), 32'd0);
    out_ready    = 1'b1;
    sw_enable_in = 1'b1;
    data_in      = 8'h01;
    tick();
    data_in = 8'hBE;
    tick();
    chk("t5_new_b0", 32'({out_valid, out_data, out_sof, out_eof}), 32'({1'b1, 8'h01, 2'b10}));
    chk("t5_new_port", 32'(out_port), 32'd1);
    sw_enable_in = 1'b0;
    tick();
    chk("t5_new_b1", 32'({out_valid, out_data, out_sof, out_eof}), 32'({1'b1, 8'hBE, 2'b01}));
    tick();
    chk("t5_new_empty", 32'(out_valid), 32'd0);

    // Destination above the port range
    sw_enable_in = 1'b1;
    data_in      = 8'h07;
    tick();
    data_in = 8'h21;
    tick();
`ifdef SW_IN_ADDR_FILTER_EN
    chk("t6_filtered", 32'(out_valid), 32'd0);
`else
    chk("t6_b0", 32'({out_valid, out_data, out_sof}), 32'({1'b1, 8'h07, 1'b1}));
    chk("t6_port", 32'(out_port), 32'd3);
`endif
    chk("t6_ro", 32'(read_out), 32'd0);
    sw_enable_in = 1'b0;
    tick();
`ifdef SW_IN_ADDR_FILTER_EN
    chk("t6_drop", 32'(drop_cnt), 32'd1);
    chk("t6_still_empty", 32'(out_valid), 32'd0);
`else
    chk("t6_drop", 32'(drop_cnt), 32'd0);
    chk("t6_b1", 32'({out_valid, out_data, out_eof}), 32'({1'b1, 8'h21, 1'b1}));
`endif
    tick();
    chk("t6_empty", 32'(out_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/switch_in_buf.md
# switch_in_buf

Parametrised switch ingress buffer. It accepts byte-serial frames on the `data_in`/`sw_enable_in`/`read_out` ingress protocol, tags frame boundaries, and decodes the destination port from the first byte. Frames are stored in a DEPTH-entry FIFO and presented on a valid/ready egress toward the switch crossbar. `read_out` is generalised from a plain busy flag into an almost-full backpressure signal, with overflow recovery and drop accounting.

## Interface
- `DATA_W`, 8: width of `data_in` and `out_data`.
- `DEPTH`, 16: number of FIFO entries. Power of two, at least 4.
- `NUM_PORTS`, 4: number of egress ports. Power of two, at least 2. `PW = $clog2(NUM_PORTS)`.
- `AFULL`, DEPTH-2: FIFO level at or above which `read_out` is asserted. Range 1..DEPTH-1.
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `data_in`  in  DATA_W: ingress byte, sampled while `sw_enable_in`=1.
- `sw_enable_in`  in  1: frame envelope. Each high cycle carries one byte.
- `read_out`  out  1: busy / backpressure to the ingress source.
- `out_data`  out  DATA_W: head-of-FIFO byte.
- `out_valid`  out  1: FIFO is not empty.
- `out_ready`  in  1: consumer accepts the head entry.
- `out_sof`, `out_eof`, `out_err`  out  1 each: head entry flags.
- `out_port`  out  PW: destination port of the frame currently at the head.
- `level`  out  $clog2(DEPTH)+1: FIFO occupancy.
- `drop_cnt`  out  16: count of whole frames dropped. Saturates at 0xFFFF.

## Operation
- Each FIFO entry is {data, sof, eof, err}. The FIFO is show-ahead: `out_data` and the flags reflect the head entry while `out_valid`=1. An entry is popped when `out_valid && out_ready`.
- **Hold register (HR):** each accepted byte is first captured into HR.
  - The previous HR byte is written to the FIFO with eof=0 when the next byte of the same frame arrives.
  - The HR byte is written with eof=1 on the first cycle `sw_enable_in` samples low.
  - The first byte of a frame carries sof=1. A one-byte frame has sof=eof=1.
- **States:**
  - IDLE → RX on `sw_enable_in`=1. Capture byte 0 and latch the destination as `data_in[PW-1:0]`.
  - RX → RX on `sw_enable_in`=1: write HR, recapture.
  - RX → FLUSH on `sw_enable_in`=0: write HR with eof=1 if not full. Go to IDLE once written.
  - RX → OVF when a write is required but the FIFO is full. The incoming byte is discarded and HR is kept.
  - OVF: discard all bytes until `sw_enable_in`=0, then go to FLUSH with err=1 forced on the eof entry.
  - FLUSH: waits for space, then writes the eof entry.
- A frame start seen in FLUSH (a pending terminator) drops the entire new frame: its bytes are ignored until `sw_enable_in` falls, and `drop_cnt` increments.
- `read_out` = (`level` >= AFULL) or state ∈ {OVF, FLUSH}.
- `out_port` is loaded from `out_data[PW-1:0]` when the popped head has sof=1, and is combinationally bypassed while the head has sof=1. It holds otherwise.
- Push and pop in the same cycle keep `level` unchanged and are legal when full: the pop frees the slot.

## Timing
- Reset values: `read_out`=0, `out_valid`=0, `out_sof`/`out_eof`/`out_err`=0, `out_data`=0, `out_port`=0, `level`=0, `drop_cnt`=0. HR is empty and the state is IDLE.
- Reset asserted mid-frame aborts the frame. The FIFO is emptied and nothing of the partial frame is ever presented.
- Latency: a byte sampled at edge N is written at edge N+1 at the earliest (next byte or envelope fall). It is visible on `out_data` after edge N+1.
- `read_out` and `level` are registered and update one cycle after the push or pop that changes them.
- Pointers wrap modulo DEPTH. Full/empty use an extra pointer MSB.

## Configuration
- `SW_IN_ADDR_FILTER_EN` defined: a frame whose first byte has any bit set above bit PW-1 (DA >= NUM_PORTS) is dropped whole. No FIFO writes occur for it, `drop_cnt` increments at the envelope fall, and `read_out` is unaffected.
- `SW_IN_ADDR_FILTER_EN` undefined: all frames are accepted and the port is the low PW bits of DA.

## Test plan
- **Single frame:** 3-byte frame 0x02,0xAA,0x55 with `out_ready`=1 → 3 entries. sof on 0x02, eof on 0x55, `out_port`=2, `out_err`=0.
- **One-byte frame:** 0x01 → one entry with sof=eof=1 and `out_port`=1.
- **Backpressure:** `out_ready`=0 and a 20-byte frame with DEPTH=16 → `read_out` rises when `level` reaches 14. Overflow leaves 16 entries; the 16th has eof=0. After `out_ready`=1, a final HR entry appears with eof=1 and err=1.
- **Drop during pending flush:** a new frame starts while in FLUSH → `drop_cnt`=1 and none of its bytes are output.
- **Async reset mid-frame:** `rst_n` low during byte 2 → all outputs take their reset values immediately, and the next frame is output intact.
- **Address filter, `SW_IN_ADDR_FILTER_EN` defined:** frame with DA=0x07 at NUM_PORTS=4 → no output entries and `drop_cnt`=1. The same stimulus with the macro undefined is output with `out_port`=3.
